// File: rtl/crossy_robbers_soc_pio_pkg.sv
// Shared constants for the keys PIO: Avalon register map and edge-detect encodings.
package crossy_robbers_soc_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int DETECT_RISE = 0;
  localparam int DETECT_FALL = 1;
  localparam int DETECT_ANY  = 2;

  // One bit of edge detection: cur is the synchronized level, prev the history flop.
  function automatic logic edge_of(input int det, input logic cur, input logic prev);
    case (det)
      DETECT_RISE: return cur & ~prev;
      DETECT_FALL: return ~cur & prev;
      default:     return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/crossy_robbers_soc_keys_pio_if.sv
// Avalon-MM slave bus bundle for the keys PIO register block.
interface crossy_robbers_soc_keys_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/crossy_robbers_soc_sync2.sv
// Two-flop synchronizer with a configurable reset level so idle inputs never look like edges.
module crossy_robbers_soc_sync2 #(
  parameter int   W       = 1,
  parameter logic RST_LVL = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= {W{RST_LVL}};
      q  <= {W{RST_LVL}};
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/crossy_robbers_soc_keys_pio.sv
// Push-button PIO: synchronized inputs, per-bit edge capture (W1C) and optional masked irq.
// Define KEYS_PIO_IRQ_EN to build the mask register and irq; otherwise capture is poll-only.
module crossy_robbers_soc_keys_pio
  import crossy_robbers_soc_pio_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DETECT   = 1,
  parameter int IDLE_LVL = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  crossy_robbers_soc_keys_pio_if.slave   avs,
  input  logic [WIDTH-1:0]               in_port,
  output logic                           irq
);

  localparam logic IDLE_BIT = (IDLE_LVL != 0);

  logic [WIDTH-1:0] s2, s3, edge_v, cap, mask, clr;
  logic             wr;

  crossy_robbers_soc_sync2 #(.W(WIDTH), .RST_LVL(IDLE_BIT)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (s2)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s3 <= {WIDTH{IDLE_BIT}};
    else          s3 <= s2;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign edge_v[i] = edge_of(DETECT, s2[i], s3[i]);
  end

  assign wr  = avs.chipselect & ~avs.write_n;
  assign clr = (wr && avs.address == ADDR_EDGE) ? avs.writedata[WIDTH-1:0] : '0;

  // A fresh edge in the same cycle as its clear wins, so no press is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cap <= '0;
    else          cap <= (cap & ~clr) | edge_v;
  end

`ifdef KEYS_PIO_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             mask <= '0;
    else if (wr && avs.address == ADDR_MASK)  mask <= avs.writedata[WIDTH-1:0];
  end

  assign irq = |(cap & mask);
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) avs.readdata <= '0;
    else begin
      case (avs.address)
        ADDR_DATA: avs.readdata <= 32'(s2);
        ADDR_MASK: avs.readdata <= 32'(mask);
        ADDR_EDGE: avs.readdata <= 32'(cap);
        default:   avs.readdata <= '0;
      endcase
    end
  end

  // Only the low WIDTH bits of writedata are meaningful.
  logic unused_wd;
  assign unused_wd = ^avs.writedata;

endmodule
